sobel_gradient_gen: RTL and testbench

- Streaming 3x3 Sobel front end. Consumes raster-order 8-bit grayscale pixels and produces per-pixel horizontal and vertical gradient magnitudes |gx| and |gy|.
- Outputs feed the downstream total-gradient stage, which sums them and saturates to 8 bits.
- Contains two line buffers, a 3x3 window, row/column counters and a 2-stage arithmetic pipeline.
- No backpressure.

---
 rtl/sobel_pkg.sv | 28 ++
 rtl/sobel_line_buffer.sv | 26 ++
 rtl/sobel_gradient_gen.sv | 148 ++++++++++++++
 tb/tb_sobel_gradient_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and arithmetic helpers for the streaming 3x3 Sobel front end.
package sobel_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned GRAD_W = 11;
    localparam int unsigned SUM_W  = 10;

    typedef logic [PIX_W-1:0]         pixel_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic [SUM_W-1:0]         sum_t;

    typedef enum logic [0:0] {
        WAIT_SOF,
        ACTIVE
    } state_t;

    // a + 2b + c; at most 1020, so 10 bits never overflow.
    function automatic sum_t wsum(pixel_t a, pixel_t b, pixel_t c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic grad_t abs_diff(sum_t pos, sum_t neg);
        grad_t d;
        d = $signed({1'b0, pos}) - $signed({1'b0, neg});
        return (d < 0) ? -d : d;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage; the read port is registered and returns the
// word as it was before a write to the same address on the same edge.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned Depth = 640,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [AddrW-1:0] rd_addr_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  pixel_t           wr_data_i,
    output pixel_t           rd_data_o
);

    pixel_t mem [Depth];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rd_data_o      <= mem[rd_addr_i];
            mem[wr_addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/sobel_gradient_gen.sv
// Streaming 3x3 Sobel front end: raster pixels in, |gx| and |gy| per interior
// pixel out, two clocks after the pixel that completes each window.
module sobel_gradient_gen
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_in,
    output logic             grad_valid,
    output logic             grad_last,
    output grad_t            gx,
    output grad_t            gy
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);

    state_t        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] col_prev_q;
    logic          accept;
    logic          at_eol;
    logic          at_eof;
    logic          win_valid_q;
    logic          win_last_q;

    // Window: columns 0 and 1 live here; column 2 is the line-buffer read
    // registers plus the registered input pixel.
    pixel_t w00_q, w01_q, w10_q, w11_q, w20_q, w21_q;
    pixel_t w02, w12, w22;
    pixel_t pix_q;
    pixel_t lb0_rd, lb1_rd;

    sum_t gx_pos_q, gx_neg_q, gy_pos_q, gy_neg_q;
    logic sum_valid_q;
    logic sum_last_q;

    // A pixel carrying sof is always (0,0), whatever the current position.
    always_comb begin
        accept  = pix_valid && (pix_sof || (state_q == ACTIVE));
        cur_col = pix_sof ? '0 : col_q;
        cur_row = pix_sof ? '0 : row_q;
        at_eol  = (cur_col == CW'(IMG_WIDTH - 1));
        at_eof  = at_eol && (cur_row == RW'(IMG_HEIGHT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_SOF;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            win_valid_q <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            win_last_q  <= accept && at_eof;
            if (accept) begin
                state_q <= at_eof ? WAIT_SOF : ACTIVE;
                if (at_eol) begin
                    col_q <= '0;
                    row_q <= cur_row + 1'b1;
                end else begin
                    col_q <= cur_col + 1'b1;
                    row_q <= cur_row;
                end
            end
        end
    end

    sobel_line_buffer #(
        .Depth (IMG_WIDTH),
        .AddrW (CW)
    ) u_lb0 (
        .clk_i     (clk),
        .en_i      (accept),
        .rd_addr_i (cur_col),
        .wr_addr_i (cur_col),
        .wr_data_i (pix_in),
        .rd_data_o (lb0_rd)
    );

    // lb1 takes lb0's old word one accept later, at the column just read, so
    // every buffer only needs its registered read port. The entry is written
    // well before the next line reads that column.
    sobel_line_buffer #(
        .Depth (IMG_WIDTH),
        .AddrW (CW)
    ) u_lb1 (
        .clk_i     (clk),
        .en_i      (accept),
        .rd_addr_i (cur_col),
        .wr_addr_i (col_prev_q),
        .wr_data_i (lb0_rd),
        .rd_data_o (lb1_rd)
    );

    always_comb begin
        w02 = lb1_rd;
        w12 = lb0_rd;
        w22 = pix_q;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pix_q      <= pix_in;
            col_prev_q <= cur_col;
            w00_q      <= w01_q;
            w01_q      <= w02;
            w10_q      <= w11_q;
            w11_q      <= w12;
            w20_q      <= w21_q;
            w21_q      <= w22;
        end
        gx_pos_q <= wsum(w02, w12, w22);
        gx_neg_q <= wsum(w00_q, w10_q, w20_q);
        gy_pos_q <= wsum(w20_q, w21_q, w22);
        gy_neg_q <= wsum(w00_q, w01_q, w02);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_valid_q <= 1'b0;
            sum_last_q  <= 1'b0;
            grad_valid  <= 1'b0;
            grad_last   <= 1'b0;
            gx          <= '0;
            gy          <= '0;
        end else begin
            sum_valid_q <= win_valid_q;
            sum_last_q  <= win_last_q;
            grad_valid  <= sum_valid_q;
            grad_last   <= sum_valid_q && sum_last_q;
            if (sum_valid_q) begin
                gx <= abs_diff(gx_pos_q, gx_neg_q);
                gy <= abs_diff(gy_pos_q, gy_neg_q);
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient_gen.sv
// Directed bench for sobel_gradient_gen on an 8x5 image with a frame-level
// reference model and per-cycle output comparison.
module tb_sobel_gradient_gen;

    localparam int W = 8;
    localparam int H = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pix_valid = 1'b0;
    logic              pix_sof = 1'b0;
    logic [7:0]        pix_in = 8'd0;
    logic              grad_valid;
    logic              grad_last;
    logic signed [10:0] gx;
    logic signed [10:0] gy;

    sobel_gradient_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_in     (pix_in),
        .grad_valid (grad_valid),
        .grad_last  (grad_last),
        .gx         (gx),
        .gy         (gy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gx;
        int gy;
        bit last;
        int cyc;
        int r;
        int c;
    } exp_t;

    exp_t expq[$];
    int   nchecks = 0;
    int   nerrors = 0;
    int   cyc = 0;
    logic rst_at_edge = 1'b1;
    int   npulse = 0;
    int   nlast = 0;
    int   hold_gx = 0;
    int   hold_gy = 0;
    int   dut_gx [H][W];
    int   dut_gy [H][W];

    int   img [H][W];
    bit   m_active = 1'b0;
    int   mr = 0;
    int   mc = 0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        nchecks++;
        if (got !== want) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Frame-level model: the bench's own idea of position, image contents and
    // the Sobel result for every completed window.
    task automatic model_accept(input int p, input bit sof);
        exp_t e;
        bit   take;
        take = 1'b1;
        if (sof) begin
            m_active = 1'b1;
            mr = 0;
            mc = 0;
        end else if (!m_active) begin
            take = 1'b0;
        end
        if (take) begin
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                e.r = mr - 1;
                e.c = mc - 1;
                e.gx = iabs((img[e.r-1][e.c+1] + 2*img[e.r][e.c+1] + img[e.r+1][e.c+1]) -
                            (img[e.r-1][e.c-1] + 2*img[e.r][e.c-1] + img[e.r+1][e.c-1]));
                e.gy = iabs((img[e.r+1][e.c-1] + 2*img[e.r+1][e.c] + img[e.r+1][e.c+1]) -
                            (img[e.r-1][e.c-1] + 2*img[e.r-1][e.c] + img[e.r-1][e.c+1]));
                e.last = (mr == H-1) && (mc == W-1);
                e.cyc = cyc + 3;
                expq.push_back(e);
            end
            if (mc == W-1) begin
                mc = 0;
                if (mr == H-1) m_active = 1'b0;
                else mr++;
            end else begin
                mc++;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_at_edge) begin
            check("rst_grad_valid", grad_valid, 0);
            check("rst_grad_last", grad_last, 0);
            check("rst_gx", gx, 0);
            check("rst_gy", gy, 0);
            hold_gx = 0;
            hold_gy = 0;
        end else if (grad_valid === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_grad_valid", grad_valid, 0);
            end else begin
                e = expq.pop_front();
                check("gx", gx, e.gx);
                check("gy", gy, e.gy);
                check("grad_last", grad_last, e.last);
                check("latency", cyc, e.cyc);
                dut_gx[e.r][e.c] = gx;
                dut_gy[e.r][e.c] = gy;
                hold_gx = gx;
                hold_gy = gy;
            end
            npulse++;
            if (grad_last === 1'b1) nlast++;
        end else begin
            check("idle_grad_valid", grad_valid, 0);
            check("idle_grad_last", grad_last, 0);
            check("hold_gx", gx, hold_gx);
            check("hold_gy", gy, hold_gy);
        end
    end

    function automatic int pix_of(input int pat, input int r, input int c);
        case (pat)
            0:       return 100;
            1:       return (c >= 4) ? 255 : 0;
            2:       return (r >= 2) ? 255 : 0;
            default: return int'($urandom_range(255));
        endcase
    endfunction

    task automatic send(input int p, input bit sof, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_in    = p[7:0];
        model_accept(p, sof);
    endtask

    task automatic send_frame(input int pat, input int maxgap, input int npix);
        for (int i = 0; i < npix; i++) begin
            send(pix_of(pat, i / W, i % W), i == 0,
                 (maxgap > 0) ? int'($urandom_range(maxgap)) : 0);
        end
    endtask

    task automatic drain(input string name);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check(name, expq.size(), 0);
    endtask

    task automatic reset_stats();
        npulse = 0;
        nlast  = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                dut_gx[r][c] = -1;
                dut_gy[r][c] = -1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Constant frame, preceded by stray pixels that must be dropped.
        reset_stats();
        send(55, 1'b0, 0);
        send(77, 1'b0, 1);
        send(99, 1'b0, 0);
        send_frame(0, 0, W*H);
        drain("t1_drain");
        check("t1_pulses", npulse, 18);
        check("t1_last_count", nlast, 1);
        check("t1_gx_2_3", dut_gx[2][3], 0);
        check("t1_gy_3_6", dut_gy[3][6], 0);

        // Vertical edge.
        reset_stats();
        send_frame(1, 0, W*H);
        drain("t2_drain");
        check("t2_pulses", npulse, 18);
        check("t2_gx_1_3", dut_gx[1][3], 1020);
        check("t2_gx_2_4", dut_gx[2][4], 1020);
        check("t2_gx_3_2", dut_gx[3][2], 0);
        check("t2_gx_2_5", dut_gx[2][5], 0);
        check("t2_gy_1_3", dut_gy[1][3], 0);

        // Horizontal edge.
        reset_stats();
        send_frame(2, 0, W*H);
        drain("t3_drain");
        check("t3_pulses", npulse, 18);
        check("t3_gy_1_4", dut_gy[1][4], 1020);
        check("t3_gy_2_1", dut_gy[2][1], 1020);
        check("t3_gy_3_3", dut_gy[3][3], 0);
        check("t3_gx_2_2", dut_gx[2][2], 0);

        // Vertical edge with random input gaps.
        reset_stats();
        send_frame(1, 3, W*H);
        drain("t4_drain");
        check("t4_pulses", npulse, 18);
        check("t4_last_count", nlast, 1);
        check("t4_gx_3_4", dut_gx[3][4], 1020);
        check("t4_gx_1_1", dut_gx[1][1], 0);

        // Reset mid row 3: in-flight results must vanish.
        send_frame(2, 0, 3*W + 5);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        rst       = 1'b1;
        while (expq.size() != 0 && expq[$].cyc > cyc) void'(expq.pop_back());
        m_active = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        reset_stats();
        repeat (6) @(posedge clk);
        #1;
        check("t5_no_stale", npulse, 0);
        send_frame(1, 0, W*H);
        drain("t5_drain");
        check("t5_pulses", npulse, 18);
        check("t5_last_count", nlast, 1);
        check("t5_gx_2_3", dut_gx[2][3], 1020);

        // Second sof arriving where (2,4) would be.
        reset_stats();
        send_frame(3, 0, 2*W + 4);
        send_frame(1, 0, W*H);
        drain("t6_drain");
        check("t6_pulses", npulse, 20);
        check("t6_last_count", nlast, 1);
        check("t6_gx_2_3", dut_gx[2][3], 1020);
        check("t6_gx_3_6", dut_gx[3][6], 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
